reg_file_port_seq: RTL and testbench
====================================

Name: reg_file_port_seq

Overview:
- Initiator that drives the single-port RegFile access interface (op, rw, reg_idx, data_w, data_r).
- Accepts one decode-stage request at a time. A request may carry up to two source reads (rs1, rs2) and one destination write (rd).
- Serialises these accesses onto the one RegFile port and returns both read operands in a single response beat.
- Sits between the decode/issue logic and RegFile, replacing ad-hoc direct port driving.

Parameters:
- REG_IDX_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.
- RF_READ_LATENCY, 1, cycles from the RegFile sampling edge to valid data_r. Legal range 1..4.
- ZERO_REG_BYPASS, 1, when 1, index 0 is hardwired zero: reads of index 0 are not issued and return 0, and writes to index 0 are suppressed.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_rs1  in  REG_IDX_WIDTH  source 1 index.
- req_rs1_en  in  1  read rs1.
- req_rs2  in  REG_IDX_WIDTH  source 2 index.
- req_rs2_en  in  1  read rs2.
- req_rd  in  REG_IDX_WIDTH  destination index.
- req_rd_en  in  1  write rd.
- req_rd_data  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rs1_data  out  DATA_WIDTH  rs1 value (0 if not read).
- rsp_rs2_data  out  DATA_WIDTH  rs2 value (0 if not read).
- rf_op  out  1  RegFile access strobe.
- rf_rw  out  1  1 = write, 0 = read.
- rf_reg_idx  out  REG_IDX_WIDTH  RegFile index.
- rf_data_w  out  DATA_WIDTH  RegFile write data.
- rf_data_r  in  DATA_WIDTH  RegFile read data.

Behaviour:
- Clocking and reset
  - One clock, sys_clk. Reset is synchronous and active-high on sys_rst.
  - All outputs are registered.
  - Reset values: req_ready=1, rsp_valid=0, rsp_rs1_data=0, rsp_rs2_data=0, rf_op=0, rf_rw=0, rf_reg_idx=0, rf_data_w=0. State=IDLE.
- RegFile timing contract
  - RegFile samples rf_* on the rising edge that ends a cycle with rf_op=1.
  - A write commits at that edge.
  - For a read, rf_data_r is valid RF_READ_LATENCY cycles after that edge. It is captured on the edge ending the last wait cycle.
- States: IDLE, RD1, W1, RD2, W2, WR, RESP.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready: latch all req_* fields, clear both result registers, drop req_ready, and go to the first needed phase.
  - Phase order is RD1 -> RD2 -> WR -> RESP.
- Phase skipping
  - The RD1 phase is needed iff rs1_en=1 and not (ZERO_REG_BYPASS and rs1==0). RD2 follows the same rule.
  - WR is needed iff rd_en=1 and not (ZERO_REG_BYPASS and rd==0).
  - Skipped read phases leave the result at 0.
- RD1 / RD2
  - One cycle: rf_op=1, rf_rw=0, rf_reg_idx=latched index.
  - Then go to W1 / W2.
- W1 / W2
  - rf_op=0. Count RF_READ_LATENCY cycles.
  - On the final count edge, capture rf_data_r into the rs1 / rs2 result register.
  - Then go to the next needed phase.
- WR
  - One cycle: rf_op=1, rf_rw=1, rf_reg_idx=rd, rf_data_w=rd_data.
  - Then go to RESP.
- RESP
  - rsp_valid=1, with data stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_valid=0, req_ready=1, state=IDLE. No new request is accepted in the handshake cycle.
- Idle bus values: whenever rf_op=0, rf_rw, rf_reg_idx and rf_data_w are driven 0.
- Ordering: reads always precede the write. If rs==rd, the response returns the pre-write value.
- Latency: cycles from accept edge to rsp_valid rising equal 1 + reads*(1+RF_READ_LATENCY) + writes.
  - Latency 1, two reads plus a write: rsp_valid high 6 cycles after the accept edge.
  - No phases needed: rsp_valid high 1 cycle after accept.
- Other rules
  - rs1==rs2 still issues two separate reads.
  - Request fields that change after acceptance are ignored.
  - rsp_ready asserted outside RESP has no effect.
- Reset mid-operation: the next edge returns to IDLE and drives reset values.
  - A write not yet issued is abandoned.
  - A write issued in the same cycle as sys_rst=1 is still seen by RegFile; this is the RegFile's concern.
  - Any pending response is dropped.

Test Plan:
- Write loop: for i=1..31, request rd=i, rd_en=1, rd_data=i*3, no reads. Then read all of them back as rs1=i, rs2=i. Required: rsp_rs1_data=rsp_rs2_data=i*3 for every i.
- x0 handling: write rd=0, data=0xDEADBEEF, then read rs1=0. Required: rf_op never asserted, rsp_rs1_data=0, and each response arrives 1 cycle after accept.
- Read-before-write: preload r5=0x11. Then request rs1=5, rd=5, rd_data=0x22. Required: rsp_rs1_data=0x11, then a later read of r5 returns 0x22. Bus order is read idx 5, then write idx 5.
- Latency and backpressure: with RF_READ_LATENCY=3, issue rs1=1, rs2=2, rd=3. Required: rsp_valid exactly 10 cycles after accept. Hold rsp_ready=0 for 5 cycles: rsp data stable and req_ready=0 throughout.
- Reset mid-operation: assert sys_rst for one cycle during W1 of a rs1+rd request. Required: next cycle req_ready=1, rf_op=0, rsp_valid=0, and the rd register is unchanged on readback.

Source files
------------

// File: rtl/reg_file_port_seq.sv
// reg_file_port_seq: serialises up to two reads and one write per decode
// request onto the single RegFile port and returns both operands together.
// Ports:
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   req_valid/req_ready, req_*       decode-side request (rs1, rs2, rd, data)
//   rsp_valid/rsp_ready, rsp_rs*     response with both read operands
//   rf_op, rf_rw, rf_reg_idx,
//   rf_data_w, rf_data_r             single RegFile access port
module reg_file_port_seq #(
   parameter int REG_IDX_WIDTH   = 5,
   parameter int DATA_WIDTH      = 32,
   parameter int RF_READ_LATENCY = 1,
   parameter int ZERO_REG_BYPASS = 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [REG_IDX_WIDTH-1:0] req_rs1,
   input  logic                     req_rs1_en,
   input  logic [REG_IDX_WIDTH-1:0] req_rs2,
   input  logic                     req_rs2_en,
   input  logic [REG_IDX_WIDTH-1:0] req_rd,
   input  logic                     req_rd_en,
   input  logic [DATA_WIDTH-1:0]    req_rd_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_rs1_data,
   output logic [DATA_WIDTH-1:0]    rsp_rs2_data,
   output logic                     rf_op,
   output logic                     rf_rw,
   output logic [REG_IDX_WIDTH-1:0] rf_reg_idx,
   output logic [DATA_WIDTH-1:0]    rf_data_w,
   input  logic [DATA_WIDTH-1:0]    rf_data_r
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD1, S_W1, S_RD2, S_W2, S_WR, S_RESP
   } state_t;

   localparam logic [1:0] LP_LAST = 2'(RF_READ_LATENCY - 1);

   state_t                   r_state;
   state_t                   w_next;
   logic [REG_IDX_WIDTH-1:0] r_rs1, r_rs2, r_rd;
   logic                     r_rs1_en, r_rs2_en, r_rd_en;
   logic [DATA_WIDTH-1:0]    r_rd_data;
   logic [1:0]               r_cnt;

   logic                     w_acc;
   logic                     w_done;
   logic [REG_IDX_WIDTH-1:0] w_rs1, w_rs2, w_rd;
   logic                     w_rs1_en, w_rs2_en, w_rd_en;
   logic [DATA_WIDTH-1:0]    w_rd_data;
   logic                     w_need1, w_need2, w_needw;

   assign w_acc  = req_valid && req_ready && (r_state == S_IDLE);
   assign w_done = (r_cnt == LP_LAST);

   // In the accept cycle the phase plan comes straight from the request;
   // afterwards only the latched copy is used.
   assign w_rs1     = w_acc ? req_rs1     : r_rs1;
   assign w_rs2     = w_acc ? req_rs2     : r_rs2;
   assign w_rd      = w_acc ? req_rd      : r_rd;
   assign w_rs1_en  = w_acc ? req_rs1_en  : r_rs1_en;
   assign w_rs2_en  = w_acc ? req_rs2_en  : r_rs2_en;
   assign w_rd_en   = w_acc ? req_rd_en   : r_rd_en;
   assign w_rd_data = w_acc ? req_rd_data : r_rd_data;

   assign w_need1 = w_rs1_en && !((ZERO_REG_BYPASS != 0) && (w_rs1 == '0));
   assign w_need2 = w_rs2_en && !((ZERO_REG_BYPASS != 0) && (w_rs2 == '0));
   assign w_needw = w_rd_en  && !((ZERO_REG_BYPASS != 0) && (w_rd  == '0));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_acc)
            w_next = w_need1 ? S_RD1 :
                     w_need2 ? S_RD2 :
                     w_needw ? S_WR  : S_RESP;
         S_RD1:  w_next = S_W1;
         S_W1:   if (w_done)
            w_next = w_need2 ? S_RD2 :
                     w_needw ? S_WR  : S_RESP;
         S_RD2:  w_next = S_W2;
         S_W2:   if (w_done)
            w_next = w_needw ? S_WR : S_RESP;
         S_WR:   w_next = S_RESP;
         S_RESP: if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state      <= S_IDLE;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_rs1_en     <= 1'b0;
         r_rs2_en     <= 1'b0;
         r_rd_en      <= 1'b0;
         r_rd_data    <= '0;
         r_cnt        <= '0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rs1_data <= '0;
         rsp_rs2_data <= '0;
         rf_op        <= 1'b0;
         rf_rw        <= 1'b0;
         rf_reg_idx   <= '0;
         rf_data_w    <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_rs1        <= req_rs1;
            r_rs2        <= req_rs2;
            r_rd         <= req_rd;
            r_rs1_en     <= req_rs1_en;
            r_rs2_en     <= req_rs2_en;
            r_rd_en      <= req_rd_en;
            r_rd_data    <= req_rd_data;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
         end
         if ((r_state == S_W1) || (r_state == S_W2)) begin
            r_cnt <= w_done ? 2'd0 : r_cnt + 2'd1;
            if (w_done && (r_state == S_W1)) rsp_rs1_data <= rf_data_r;
            if (w_done && (r_state == S_W2)) rsp_rs2_data <= rf_data_r;
         end
         // Bus outputs are a registered decode of the state being entered;
         // the bus is all-zero whenever no access is issued.
         req_ready <= (w_next == S_IDLE);
         rsp_valid <= (w_next == S_RESP);
         rf_op     <= (w_next == S_RD1) || (w_next == S_RD2) ||
                      (w_next == S_WR);
         rf_rw     <= (w_next == S_WR);
         rf_reg_idx <= (w_next == S_RD1) ? w_rs1 :
                       (w_next == S_RD2) ? w_rs2 :
                       (w_next == S_WR)  ? w_rd  : '0;
         rf_data_w <= (w_next == S_WR) ? w_rd_data : '0;
      end
   end

endmodule

// File: tb/tb_reg_file_port_seq.sv
// tb_reg_file_port_seq: checks the RegFile port sequencer against a
// behavioural RegFile at read latencies 1 (inst 0) and 3 (inst 1).
module tb_reg_file_port_seq;

   logic        sys_clk;
   logic        sys_rst;
   logic        model_clr;
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic [4:0]  req_rs1      [2];
   logic        req_rs1_en   [2];
   logic [4:0]  req_rs2      [2];
   logic        req_rs2_en   [2];
   logic [4:0]  req_rd       [2];
   logic        req_rd_en    [2];
   logic [31:0] req_rd_data  [2];
   logic        rsp_valid    [2];
   logic        rsp_ready    [2];
   logic [31:0] rsp_rs1_data [2];
   logic [31:0] rsp_rs2_data [2];
   logic        rf_op        [2];
   logic        rf_rw        [2];
   logic [4:0]  rf_reg_idx   [2];
   logic [31:0] rf_data_w    [2];
   logic [31:0] rf_data_r    [2];

   int total;
   int bad;

   reg_file_port_seq #(.RF_READ_LATENCY(1)) u_dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_rs1(req_rs1[0]), .req_rs1_en(req_rs1_en[0]),
      .req_rs2(req_rs2[0]), .req_rs2_en(req_rs2_en[0]),
      .req_rd(req_rd[0]), .req_rd_en(req_rd_en[0]),
      .req_rd_data(req_rd_data[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rs1_data(rsp_rs1_data[0]), .rsp_rs2_data(rsp_rs2_data[0]),
      .rf_op(rf_op[0]), .rf_rw(rf_rw[0]), .rf_reg_idx(rf_reg_idx[0]),
      .rf_data_w(rf_data_w[0]), .rf_data_r(rf_data_r[0])
   );

   reg_file_port_seq #(.RF_READ_LATENCY(3)) u_dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_rs1(req_rs1[1]), .req_rs1_en(req_rs1_en[1]),
      .req_rs2(req_rs2[1]), .req_rs2_en(req_rs2_en[1]),
      .req_rd(req_rd[1]), .req_rd_en(req_rd_en[1]),
      .req_rd_data(req_rd_data[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rs1_data(rsp_rs1_data[1]), .rsp_rs2_data(rsp_rs2_data[1]),
      .rf_op(rf_op[1]), .rf_rw(rf_rw[1]), .rf_reg_idx(rf_reg_idx[1]),
      .rf_data_w(rf_data_w[1]), .rf_data_r(rf_data_r[1])
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural RegFile per instance, plus bus activity counters.
   logic [31:0] mem      [2][32];
   logic [31:0] pipe     [2][4];
   int          opcnt    [2];
   int          idle_bad [2];

   for (genvar g = 0; g < 2; g++) begin : g_rf
      assign rf_data_r[g] = pipe[g][(g == 0) ? 0 : 2];
      always @(posedge sys_clk) begin
         if (model_clr) begin
            for (int i = 0; i < 32; i++) mem[g][i] <= 32'hA5A5_0000 + i;
            for (int k = 0; k < 4; k++) pipe[g][k] <= 32'hBAD0_BAD0;
            opcnt[g]    <= 0;
            idle_bad[g] <= 0;
         end else begin
            if (rf_op[g] && rf_rw[g]) mem[g][rf_reg_idx[g]] <= rf_data_w[g];
            pipe[g][0] <= (rf_op[g] && !rf_rw[g]) ?
                          mem[g][rf_reg_idx[g]] : 32'hBAD0_BAD0;
            for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
            if (rf_op[g]) opcnt[g] <= opcnt[g] + 1;
            if (!rf_op[g] && (rf_rw[g] || rf_reg_idx[g] != 0 ||
                rf_data_w[g] != 0))
               idle_bad[g] <= idle_bad[g] + 1;
         end
      end
   end

   typedef struct packed {
      logic        rw;
      logic [4:0]  idx;
      logic [31:0] d;
   } bus_t;
   bus_t blog[$];

   always @(posedge sys_clk)
      if (!model_clr && rf_op[0])
         blog.push_back({rf_rw[0], rf_reg_idx[0], rf_data_w[0]});

   typedef struct {
      logic [31:0] x1;
      logic [31:0] x2;
      int          lat;
      int          ops;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [4:0]  rs1;
      logic        e1;
      logic [4:0]  rs2;
      logic        e2;
      logic [4:0]  rd;
      logic        ew;
      logic [31:0] wd;
      logic [31:0] x1;
      logic [31:0] x2;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, req);
      end
   endtask

   task automatic txn(input int d,
                      input logic [4:0] rs1, input logic e1,
                      input logic [4:0] rs2, input logic e2,
                      input logic [4:0] rd, input logic ew,
                      input logic [31:0] wd,
                      input logic [31:0] x1, input logic [31:0] x2,
                      input int hold, input string nm);
      int   nr, nw, k, ops0, lat;
      exp_t e;
      nr  = ((e1 && rs1 != 0) ? 1 : 0) + ((e2 && rs2 != 0) ? 1 : 0);
      nw  = (ew && rd != 0) ? 1 : 0;
      lat = (d == 0) ? 1 : 3;
      sbq.push_back('{x1, x2, 1 + nr * (1 + lat) + nw, nr + nw});
      k = 0;
      while (!req_ready[d] && k < 50) begin
         @(posedge sys_clk); #1; k++;
      end
      chk({nm, " ready"}, 64'(req_ready[d]), 64'd1);
      req_rs1[d] = rs1; req_rs1_en[d] = e1;
      req_rs2[d] = rs2; req_rs2_en[d] = e2;
      req_rd[d]  = rd;  req_rd_en[d]  = ew;
      req_rd_data[d] = wd;
      req_valid[d]   = 1'b1;
      ops0 = opcnt[d];
      @(posedge sys_clk); #1;
      req_valid[d]   = 1'b0;
      req_rs1[d]     = 5'($urandom);
      req_rs2[d]     = 5'($urandom);
      req_rd[d]      = 5'($urandom);
      req_rs1_en[d]  = 1'($urandom);
      req_rs2_en[d]  = 1'($urandom);
      req_rd_en[d]   = 1'($urandom);
      req_rd_data[d] = $urandom;
      k = 1;
      while (!rsp_valid[d] && k < 64) begin
         @(posedge sys_clk); #1; k++;
      end
      e = sbq.pop_front();
      chk({nm, " lat"}, 64'(k), 64'(e.lat));
      chk({nm, " rs1"}, 64'(rsp_rs1_data[d]), 64'(e.x1));
      chk({nm, " rs2"}, 64'(rsp_rs2_data[d]), 64'(e.x2));
      chk({nm, " ops"}, 64'(opcnt[d] - ops0), 64'(e.ops));
      for (int h = 0; h < hold; h++) begin
         @(posedge sys_clk); #1;
         chk({nm, " hold vr"}, {62'd0, rsp_valid[d], req_ready[d]}, 64'd2);
         chk({nm, " hold d"}, {rsp_rs1_data[d], rsp_rs2_data[d]},
             {e.x1, e.x2});
      end
      rsp_ready[d] = 1'b1;
      @(posedge sys_clk); #1;
      rsp_ready[d] = 1'b0;
      chk({nm, " done"}, {62'd0, rsp_valid[d], req_ready[d]}, 64'd1);
   endtask

   vec_t tbl[8];
   int   n0;

   initial begin
      total = 0;
      bad   = 0;
      tbl[0] = '{5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'hDEAD_BEEF,
                 32'd0, 32'd0};
      tbl[1] = '{5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'd0,
                 32'd0, 32'd0};
      tbl[2] = '{5'd3,  1'b1, 5'd4,  1'b1, 5'd10, 1'b1, 32'h1234,
                 32'd9, 32'd12};
      tbl[3] = '{5'd10, 1'b1, 5'd10, 1'b1, 5'd0,  1'b0, 32'd0,
                 32'h1234, 32'h1234};
      tbl[4] = '{5'd7,  1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 32'd0,
                 32'd21, 32'd0};
      tbl[5] = '{5'd0,  1'b0, 5'd31, 1'b1, 5'd0,  1'b0, 32'd0,
                 32'd0, 32'd93};
      tbl[6] = '{5'd0,  1'b1, 5'd2,  1'b1, 5'd0,  1'b0, 32'd0,
                 32'd0, 32'd6};
      tbl[7] = '{5'd12, 1'b1, 5'd13, 1'b1, 5'd12, 1'b1, 32'h77,
                 32'd36, 32'd39};

      sys_clk   = 1'b0;
      sys_rst   = 1'b1;
      model_clr = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;  rsp_ready[d] = 1'b0;
         req_rs1[d] = '0;      req_rs1_en[d] = 1'b0;
         req_rs2[d] = '0;      req_rs2_en[d] = 1'b0;
         req_rd[d]  = '0;      req_rd_en[d]  = 1'b0;
         req_rd_data[d] = '0;
      end
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst   = 1'b0;
      model_clr = 1'b0;
      @(posedge sys_clk); #1;

      for (int d = 0; d < 2; d++) begin
         chk("reset ctl", {60'd0, req_ready[d], rsp_valid[d], rf_op[d],
             rf_rw[d]}, 64'h8);
         chk("reset idx", 64'(rf_reg_idx[d]), 64'd0);
         chk("reset wdat", 64'(rf_data_w[d]), 64'd0);
         chk("reset rsp", {rsp_rs1_data[d], rsp_rs2_data[d]}, 64'd0);
      end

      for (int i = 1; i < 32; i++)
         txn(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 32'(i * 3),
             32'd0, 32'd0, 0, "wr");
      for (int i = 1; i < 32; i++)
         txn(0, 5'(i), 1'b1, 5'(i), 1'b1, 5'd0, 1'b0, 32'd0,
             32'(i * 3), 32'(i * 3), 0, "rd");

      for (int v = 0; v < 8; v++)
         txn(0, tbl[v].rs1, tbl[v].e1, tbl[v].rs2, tbl[v].e2,
             tbl[v].rd, tbl[v].ew, tbl[v].wd, tbl[v].x1, tbl[v].x2,
             (v == 7) ? 2 : 0, $sformatf("vec%0d", v));

      txn(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h11,
          32'd0, 32'd0, 0, "pre5");
      n0 = blog.size();
      txn(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 32'h22,
          32'h11, 32'd0, 0, "rbw");
      chk("rbw nbus", 64'(blog.size()), 64'(n0 + 2));
      chk("rbw bus0", 64'(blog[n0]), {26'd0, 1'b0, 5'd5, 32'd0});
      chk("rbw bus1", 64'(blog[n0+1]), {26'd0, 1'b1, 5'd5, 32'h22});
      txn(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0,
          32'h22, 32'd0, 0, "rbw rd");

      txn(1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'hCAFE,
          32'hA5A5_0001, 32'hA5A5_0002, 5, "lat3");
      txn(1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0,
          32'hCAFE, 32'd0, 0, "lat3 rd");

      req_rs1[0] = 5'd4;  req_rs1_en[0] = 1'b1;
      req_rs2[0] = 5'd0;  req_rs2_en[0] = 1'b0;
      req_rd[0]  = 5'd6;  req_rd_en[0]  = 1'b1;
      req_rd_data[0] = 32'hFFFF;
      req_valid[0]   = 1'b1;
      @(posedge sys_clk); #1;
      req_valid[0] = 1'b0;
      chk("mid rd1", {61'd0, rf_op[0], rf_rw[0], req_ready[0]}, 64'h4);
      @(posedge sys_clk); #1;
      chk("mid w1", 64'(rf_op[0]), 64'd0);
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      chk("mid rst", {61'd0, req_ready[0], rf_op[0], rsp_valid[0]},
          64'h4);
      chk("mid rsp", 64'(rsp_rs1_data[0]), 64'd0);
      txn(0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0,
          32'd18, 32'd0, 0, "mid rb");

      chk("idle bus0", 64'(idle_bad[0]), 64'd0);
      chk("idle bus1", 64'(idle_bad[1]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
